// File: rtl/sdram_port_arbiter.sv
// Front end that merges one Wishbone slave port and NUM_CH accelerator ports onto the single
// SDRAM controller request interface, routing in-order read returns back through a tag FIFO.
module sdram_port_arbiter #(
  parameter int NUM_CH   = 3,
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 32,
  parameter int MAX_RD   = 4,
  parameter int ARB_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH-1:0]        ch_rw,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  input  logic [NUM_CH-1:0]        ch_in_valid,
  input  logic [NUM_CH-1:0]        ch_prefetch_step,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH-1:0]        ch_out_valid,
  output logic [NUM_CH*DATA_W-1:0] ch_rdata,
  output logic [ADDR_W-1:0]        ctl_addr,
  output logic                     ctl_rw,
  output logic [DATA_W-1:0]        ctl_wdata,
  output logic                     ctl_prefetch_step,
  output logic [3:0]               ctl_mask,
  output logic                     ctl_in_valid,
  input  logic                     ctl_busy,
  input  logic                     ctl_out_valid,
  input  logic [DATA_W-1:0]        ctl_rdata,
  output logic [$clog2(MAX_RD):0]  rd_outstanding,
  output logic                     err_o
);

  localparam int P  = NUM_CH + 1;
  localparam int PW = $clog2(P);
  localparam int FW = $clog2(MAX_RD);
  localparam int CW = FW + 1;

  logic [P-1:0]        req_s;
  logic [PW-1:0]       grant_s;
  logic                any_req_s;
  logic                fifo_full_s;
  logic                accept_s;
  logic                push_s;
  logic                pop_s;
  logic [PW-1:0]       head_s;
  logic [PW-1:0]       head_ch_s;
  logic [PW-1:0]       grant_ch_s;
  logic [ADDR_W-1:0]   addr_s;
  logic                rw_s;
  logic [DATA_W-1:0]   wdata_s;
  logic                pf_s;
  logic [3:0]          mask_s;

  logic [PW-1:0]       rr_ptr_r;
  logic                wb_pending_r;
  logic [PW-1:0]       tag_mem_r [MAX_RD];
  logic [FW-1:0]       wr_ptr_r;
  logic [FW-1:0]       rd_ptr_r;
  logic [CW-1:0]       count_r;
  logic                err_r;
  logic                wbs_ack_r;
  logic [31:0]         wbs_dat_r;
  logic [NUM_CH-1:0]   ch_out_valid_r;
  logic [NUM_CH*DATA_W-1:0] ch_rdata_r;

  logic                unused_adr_s;
  assign unused_adr_s = ^wbs_adr_i[31:ADDR_W];

  // Request vector: the Wishbone port is masked while its previous access is in flight
  always_comb begin
    req_s        = '0;
    req_s[0]     = wbs_stb_i & wbs_cyc_i & ~wb_pending_r;
    req_s[P-1:1] = ch_in_valid;
  end

  // Grant search: cyclic from rr_ptr_r in round-robin mode, from index 0 in fixed priority
  always_comb begin
    int   idx_v;
    logic found_v;
    logic hit_v;
    grant_s = '0;
    found_v = 1'b0;
    idx_v   = 0;
    hit_v   = 1'b0;
    for (int i = 0; i < P; i++) begin
      idx_v   = (ARB_MODE == 1) ? i :
                ((int'(rr_ptr_r) + i >= P) ? int'(rr_ptr_r) + i - P : int'(rr_ptr_r) + i);
      hit_v   = req_s[idx_v[PW-1:0]] & ~found_v;
      grant_s = hit_v ? idx_v[PW-1:0] : grant_s;
      found_v = found_v | req_s[idx_v[PW-1:0]];
    end
  end

  assign any_req_s   = |req_s;
  assign fifo_full_s = (count_r == CW'(MAX_RD));
  assign accept_s    = ctl_in_valid & ~ctl_busy;
  assign push_s      = accept_s & ~rw_s;
  assign pop_s       = ctl_out_valid & (count_r != '0);
  assign head_s      = tag_mem_r[rd_ptr_r];
  assign head_ch_s   = head_s - PW'(1);
  assign grant_ch_s  = grant_s - PW'(1);

  // Request field mux from the granted port
  always_comb begin
    if (grant_s == '0) begin
      addr_s  = wbs_adr_i[ADDR_W-1:0];
      rw_s    = wbs_we_i;
      wdata_s = wbs_dat_i;
      pf_s    = 1'b0;
      mask_s  = wbs_we_i ? wbs_sel_i : 4'h0;
    end else begin
      addr_s  = ch_addr[grant_ch_s*ADDR_W +: ADDR_W];
      rw_s    = ch_rw[grant_ch_s];
      wdata_s = ch_wdata[grant_ch_s*DATA_W +: DATA_W];
      pf_s    = ch_prefetch_step[grant_ch_s];
      mask_s  = ch_rw[grant_ch_s] ? 4'hF : 4'h0;
    end
  end

  // Channel busy: low only in the cycle that channel's request is taken
  always_comb begin
    ch_busy = '1;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_busy[k] = ~(accept_s & (grant_s == PW'(k + 1)));
    end
  end

  assign ctl_in_valid      = any_req_s & ~fifo_full_s;
  assign ctl_addr          = addr_s;
  assign ctl_rw            = rw_s;
  assign ctl_wdata         = wdata_s;
  assign ctl_prefetch_step = pf_s;
  assign ctl_mask          = mask_s;

  // Tag FIFO, arbitration pointer, Wishbone pending flag and sticky return error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_RD; i++) begin
        tag_mem_r[i] <= '0;
      end
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      rr_ptr_r     <= '0;
      wb_pending_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= grant_s;
        wr_ptr_r            <= wr_ptr_r + FW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + FW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (accept_s) begin
        rr_ptr_r <= (grant_s == PW'(P - 1)) ? '0 : grant_s + PW'(1);
      end
      // The ack cycle keeps the port masked so a still-held stb is not reissued
      if (accept_s && (grant_s == '0)) begin
        wb_pending_r <= 1'b1;
      end else if (wbs_ack_r) begin
        wb_pending_r <= 1'b0;
      end
      if (ctl_out_valid && (count_r == '0)) begin
        err_r <= 1'b1;
      end
    end
  end

  // Return path: steer popped read data to its requester, plus the Wishbone write ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_r      <= 1'b0;
      wbs_dat_r      <= '0;
      ch_out_valid_r <= '0;
      ch_rdata_r     <= '0;
    end else begin
      wbs_ack_r      <= 1'b0;
      ch_out_valid_r <= '0;
      if (pop_s) begin
        if (head_s == '0) begin
          wbs_ack_r <= 1'b1;
          wbs_dat_r <= ctl_rdata;
        end else begin
          ch_out_valid_r[head_ch_s]                  <= 1'b1;
          ch_rdata_r[head_ch_s*DATA_W +: DATA_W] <= ctl_rdata;
        end
      end
      if (accept_s && (grant_s == '0) && rw_s) begin
        wbs_ack_r <= 1'b1;
      end
    end
  end

  assign wbs_ack_o      = wbs_ack_r;
  assign wbs_dat_o      = wbs_dat_r;
  assign ch_out_valid   = ch_out_valid_r;
  assign ch_rdata       = ch_rdata_r;
  assign rd_outstanding = count_r;
  assign err_o          = err_r;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus random traffic, all checked every cycle
// against a queue-based reference model; one instance per arbitration mode.
module tb_sdram_port_arbiter;

  localparam int NUM_CH = 3;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int MAX_RD = 4;
  localparam int P      = NUM_CH + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        wbs_stb, wbs_cyc, wbs_we;
  logic [3:0]  wbs_sel;
  logic [31:0] wbs_adr, wbs_dat;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_rw, ch_in_valid, ch_prefetch_step;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic        ctl_busy, ctl_out_valid;
  logic [31:0] ctl_rdata;

  logic        o0_ack, o1_ack, o0_civ, o1_civ, o0_rw, o1_rw, o0_pf, o1_pf, o0_err, o1_err;
  logic [31:0] o0_dat, o1_dat, o0_wdata, o1_wdata;
  logic [2:0]  o0_busy, o1_busy, o0_ov, o1_ov, o0_out, o1_out;
  logic [95:0] o0_rdata, o1_rdata;
  logic [23:0] o0_addr, o1_addr;
  logic [3:0]  o0_mask, o1_mask;

  sdram_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD(MAX_RD), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wbs_stb_i(wbs_stb), .wbs_cyc_i(wbs_cyc), .wbs_we_i(wbs_we),
    .wbs_sel_i(wbs_sel), .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat), .wbs_ack_o(o0_ack), .wbs_dat_o(o0_dat),
    .ch_addr(ch_addr), .ch_rw(ch_rw), .ch_wdata(ch_wdata), .ch_in_valid(ch_in_valid),
    .ch_prefetch_step(ch_prefetch_step), .ch_busy(o0_busy), .ch_out_valid(o0_ov), .ch_rdata(o0_rdata),
    .ctl_addr(o0_addr), .ctl_rw(o0_rw), .ctl_wdata(o0_wdata), .ctl_prefetch_step(o0_pf),
    .ctl_mask(o0_mask), .ctl_in_valid(o0_civ), .ctl_busy(ctl_busy), .ctl_out_valid(ctl_out_valid),
    .ctl_rdata(ctl_rdata), .rd_outstanding(o0_out), .err_o(o0_err));

  sdram_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD(MAX_RD), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wbs_stb_i(wbs_stb), .wbs_cyc_i(wbs_cyc), .wbs_we_i(wbs_we),
    .wbs_sel_i(wbs_sel), .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat), .wbs_ack_o(o1_ack), .wbs_dat_o(o1_dat),
    .ch_addr(ch_addr), .ch_rw(ch_rw), .ch_wdata(ch_wdata), .ch_in_valid(ch_in_valid),
    .ch_prefetch_step(ch_prefetch_step), .ch_busy(o1_busy), .ch_out_valid(o1_ov), .ch_rdata(o1_rdata),
    .ctl_addr(o1_addr), .ctl_rw(o1_rw), .ctl_wdata(o1_wdata), .ctl_prefetch_step(o1_pf),
    .ctl_mask(o1_mask), .ctl_in_valid(o1_civ), .ctl_busy(ctl_busy), .ctl_out_valid(ctl_out_valid),
    .ctl_rdata(ctl_rdata), .rd_outstanding(o1_out), .err_o(o1_err));

  // Outputs of whichever instance is under check; sel_dut also selects the model's arbitration mode
  bit sel_dut = 1'b0;
  logic        ob_ack, ob_civ, ob_rw, ob_pf, ob_err;
  logic [31:0] ob_dat, ob_wdata;
  logic [2:0]  ob_busy, ob_ov, ob_out;
  logic [95:0] ob_rdata;
  logic [23:0] ob_addr;
  logic [3:0]  ob_mask;
  assign ob_ack   = sel_dut ? o1_ack   : o0_ack;
  assign ob_civ   = sel_dut ? o1_civ   : o0_civ;
  assign ob_rw    = sel_dut ? o1_rw    : o0_rw;
  assign ob_pf    = sel_dut ? o1_pf    : o0_pf;
  assign ob_err   = sel_dut ? o1_err   : o0_err;
  assign ob_dat   = sel_dut ? o1_dat   : o0_dat;
  assign ob_wdata = sel_dut ? o1_wdata : o0_wdata;
  assign ob_busy  = sel_dut ? o1_busy  : o0_busy;
  assign ob_ov    = sel_dut ? o1_ov    : o0_ov;
  assign ob_out   = sel_dut ? o1_out   : o0_out;
  assign ob_rdata = sel_dut ? o1_rdata : o0_rdata;
  assign ob_addr  = sel_dut ? o1_addr  : o0_addr;
  assign ob_mask  = sel_dut ? o1_mask  : o0_mask;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int          m_q[$];
  int          m_rr, m_g;
  bit          m_pend, m_ack, m_err, m_acc, m_civ, m_rw;
  logic [2:0]  m_ov;
  logic [31:0] m_wbdat;
  logic [31:0] m_rd [NUM_CH];

  logic        last_civ, last_ack, last_err, seen_ack;
  logic [23:0] last_addr;
  logic [31:0] last_wdata, last_wbdat;
  logic [3:0]  last_mask;
  logic [2:0]  last_ov, last_out;
  logic [95:0] last_rdata;

  task automatic model_reset();
    m_q.delete();
    m_rr = 0; m_g = -1; m_pend = 0; m_ack = 0; m_err = 0; m_acc = 0; m_civ = 0; m_rw = 0;
    m_ov = '0; m_wbdat = '0;
    for (int k = 0; k < NUM_CH; k++) m_rd[k] = '0;
  endtask

  task automatic clear_inputs();
    wbs_stb = 0; wbs_cyc = 0; wbs_we = 0; wbs_sel = '0; wbs_adr = '0; wbs_dat = '0;
    ch_addr = '0; ch_rw = '0; ch_wdata = '0; ch_in_valid = '0; ch_prefetch_step = '0;
    ctl_busy = 0; ctl_out_valid = 0; ctl_rdata = '0;
  endtask

  task automatic eval_check();
    bit          req [P];
    int          p, k;
    logic [23:0] ea;
    logic [31:0] ewd;
    logic [3:0]  em;
    logic        epf;
    logic [2:0]  eb;
    req[0] = wbs_stb && wbs_cyc && !m_pend;
    for (int j = 0; j < NUM_CH; j++) req[j+1] = ch_in_valid[j];
    m_g = -1;
    for (int i = 0; i < P; i++) begin
      p = sel_dut ? i : (m_rr + i) % P;
      if (m_g < 0 && req[p]) m_g = p;
    end
    m_civ = (m_g >= 0) && (m_q.size() < MAX_RD);
    m_acc = m_civ && !ctl_busy;
    if (m_g == 0) begin
      ea = wbs_adr[23:0]; m_rw = wbs_we; ewd = wbs_dat; epf = 0; em = wbs_we ? wbs_sel : 4'h0;
    end else begin
      k = (m_g > 0) ? m_g - 1 : 0;
      ea = ch_addr[k*ADDR_W +: ADDR_W]; m_rw = ch_rw[k]; ewd = ch_wdata[k*DATA_W +: DATA_W];
      epf = ch_prefetch_step[k]; em = ch_rw[k] ? 4'hF : 4'h0;
    end
    check_eq("ctl_in_valid", ob_civ, m_civ);
    if (m_civ) begin
      check_eq("ctl_addr", ob_addr, ea);
      check_eq("ctl_rw", ob_rw, m_rw);
      check_eq("ctl_wdata", ob_wdata, ewd);
      check_eq("ctl_mask", ob_mask, em);
      check_eq("ctl_prefetch", ob_pf, epf);
    end
    for (int j = 0; j < NUM_CH; j++) eb[j] = !(m_acc && m_g == j + 1);
    check_eq("ch_busy", ob_busy, eb);
    check_eq("wbs_ack", ob_ack, m_ack);
    check_eq("wbs_dat", ob_dat, m_wbdat);
    check_eq("ch_out_valid", ob_ov, m_ov);
    for (int j = 0; j < NUM_CH; j++) check_eq("ch_rdata", ob_rdata[j*DATA_W +: DATA_W], m_rd[j]);
    check_eq("rd_outstanding", ob_out, m_q.size());
    check_eq("err_o", ob_err, m_err);
    last_civ = ob_civ; last_addr = ob_addr; last_wdata = ob_wdata; last_mask = ob_mask;
    last_ack = ob_ack; last_wbdat = ob_dat; last_ov = ob_ov; last_rdata = ob_rdata;
    last_err = ob_err; last_out = ob_out; seen_ack = m_ack;
  endtask

  task automatic model_update();
    bit ack_now;
    int h;
    ack_now = m_ack;
    m_ack = 0;
    m_ov = '0;
    if (ctl_out_valid) begin
      if (m_q.size() == 0) m_err = 1;
      else begin
        h = m_q.pop_front();
        if (h == 0) begin m_ack = 1; m_wbdat = ctl_rdata; end
        else begin m_ov[h-1] = 1'b1; m_rd[h-1] = ctl_rdata; end
      end
    end
    if (m_acc) begin
      m_rr = (m_g + 1) % P;
      if (!m_rw) m_q.push_back(m_g);
      if (m_g == 0) begin
        m_pend = 1;
        if (m_rw) m_ack = 1;
      end
    end
    if (ack_now) m_pend = 0;
  endtask

  task automatic step();
    @(negedge clk);
    eval_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    model_reset();
    #1;
    check_eq("rst_busy", ob_busy, 3'b111);
    check_eq("rst_ack", ob_ack, 1'b0);
    check_eq("rst_ov", ob_ov, 3'b000);
    check_eq("rst_outstanding", ob_out, 3'd0);
    check_eq("rst_err", ob_err, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic set_ch(input int k, input logic v, input logic rw, input logic [23:0] a, input logic [31:0] d);
    ch_in_valid[k] = v;
    ch_rw[k] = rw;
    ch_addr[k*ADDR_W +: ADDR_W] = a;
    ch_wdata[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic random_phase(input int n);
    bit wb_act;
    wb_act = 0;
    for (int c = 0; c < n; c++) begin
      ctl_busy      = ($urandom_range(0, 3) == 0);
      ctl_out_valid = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      ctl_rdata     = $urandom;
      step();
      if (seen_ack) begin
        wb_act = 0; wbs_stb = 0; wbs_cyc = 0;
      end else if (!wb_act && $urandom_range(0, 3) == 0) begin
        wb_act = 1; wbs_stb = 1; wbs_cyc = 1;
        wbs_we = 1'($urandom_range(0, 1)); wbs_sel = 4'($urandom);
        wbs_adr = $urandom; wbs_dat = $urandom;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (!ch_in_valid[k] || (m_acc && m_g == k + 1)) begin
          set_ch(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom), $urandom);
          ch_prefetch_step[k] = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  initial begin
    clear_inputs();
    #1;
    sel_dut = 0;
    do_reset();

    // Round-robin rotation over continuously requesting channels, then a masked WB write
    for (int k = 0; k < NUM_CH; k++) set_ch(k, 1'b1, 1'b1, 24'h000100 + 24'(k), 32'hC0DE0000 + 32'(k));
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("rot_grant", last_addr, 24'h000100 + 24'(i % 3));
    end
    wbs_stb = 1; wbs_cyc = 1; wbs_we = 1; wbs_sel = 4'b0011; wbs_dat = 32'h1234; wbs_adr = 32'h40;
    step();
    check_eq("wbw_addr", last_addr, 24'h000040);
    check_eq("wbw_mask", last_mask, 4'b0011);
    check_eq("wbw_data", last_wdata, 32'h1234);
    step();
    check_eq("wbw_ack", last_ack, 1'b1);
    wbs_stb = 0; wbs_cyc = 0; ch_in_valid = '0;
    step();

    // Reads from WB, ch2, ch1 returning in order to their own ports
    do_reset();
    wbs_stb = 1; wbs_cyc = 1; wbs_we = 0; wbs_adr = 32'h0A00;
    step();
    set_ch(1, 1'b1, 1'b0, 24'h000B00, 32'h0);
    step();
    ch_in_valid = '0;
    set_ch(0, 1'b1, 1'b0, 24'h000C00, 32'h0);
    step();
    ch_in_valid = '0;
    ctl_out_valid = 1; ctl_rdata = 32'hAAAA0001;
    step();
    ctl_rdata = 32'hBBBB0002;
    step();
    check_eq("oop_wb_ack", last_ack, 1'b1);
    check_eq("oop_wb_dat", last_wbdat, 32'hAAAA0001);
    wbs_stb = 0; wbs_cyc = 0;
    ctl_rdata = 32'hCCCC0003;
    step();
    check_eq("oop_ch2_ov", last_ov, 3'b010);
    check_eq("oop_ch2_dat", last_rdata[32 +: 32], 32'hBBBB0002);
    ctl_out_valid = 0;
    step();
    check_eq("oop_ch1_ov", last_ov, 3'b001);
    check_eq("oop_ch1_dat", last_rdata[0 +: 32], 32'hCCCC0003);

    // Full tag FIFO blocks a pending write until the cycle after the first pop
    do_reset();
    wbs_stb = 1; wbs_cyc = 1; wbs_we = 0; wbs_adr = 32'h0D00;
    step();
    for (int k = 0; k < NUM_CH; k++) begin
      set_ch(k, 1'b1, 1'b0, 24'h000D01 + 24'(k), 32'h0);
      step();
      ch_in_valid = '0;
    end
    set_ch(0, 1'b1, 1'b1, 24'h000E00, 32'h5555AAAA);
    step();
    check_eq("full_block0", last_civ, 1'b0);
    step();
    check_eq("full_block1", last_civ, 1'b0);
    ctl_out_valid = 1; ctl_rdata = 32'h0D0D0D0D;
    step();
    check_eq("full_pop_cycle", last_civ, 1'b0);
    ctl_out_valid = 0;
    step();
    check_eq("full_wr_issue", last_civ, 1'b1);
    check_eq("full_wr_addr", last_addr, 24'h000E00);
    wbs_stb = 0; wbs_cyc = 0; ch_in_valid = '0;
    ctl_out_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ctl_rdata = $urandom;
      step();
    end
    ctl_out_valid = 0;
    step();

    // Fixed priority under backpressure
    sel_dut = 1;
    do_reset();
    ctl_busy = 1;
    wbs_stb = 1; wbs_cyc = 1; wbs_we = 1; wbs_sel = 4'hF; wbs_adr = 32'h0F00; wbs_dat = 32'h77;
    set_ch(2, 1'b1, 1'b1, 24'h000F03, 32'h33);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_valid", last_civ, 1'b1);
      check_eq("bp_grant0", last_addr, 24'h000F00);
    end
    ctl_busy = 0;
    step();
    check_eq("pri_first", last_addr, 24'h000F00);
    step();
    check_eq("pri_second", last_addr, 24'h000F03);
    check_eq("pri_ack", last_ack, 1'b1);
    wbs_stb = 0; wbs_cyc = 0; ch_in_valid = '0;
    step();
    check_eq("pri_no_reissue", last_civ, 1'b0);

    // Return with empty FIFO, then reset with reads in flight
    sel_dut = 0;
    do_reset();
    ctl_out_valid = 1; ctl_rdata = 32'hDEADBEEF;
    step();
    ctl_out_valid = 0;
    step();
    check_eq("err_set", last_err, 1'b1);
    set_ch(0, 1'b1, 1'b0, 24'h000111, 32'h0);
    step();
    ch_in_valid = '0;
    set_ch(1, 1'b1, 1'b0, 24'h000222, 32'h0);
    step();
    ch_in_valid = '0;
    step();
    check_eq("two_outstanding", last_out, 3'd2);
    do_reset();

    // Random traffic in each arbitration mode
    sel_dut = 0;
    do_reset();
    random_phase(2000);
    sel_dut = 1;
    do_reset();
    random_phase(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
